frame_swap_sequencer: RTL and testbench

FRAME_SWAP_SEQUENCER -- requirements
Module: frame_swap_sequencer

---
 rtl/frame_swap_sequencer_pkg.sv | 18 +
 rtl/frame_swap_sequencer_swap_handshake_timer.sv | 41 ++++
 rtl/frame_swap_sequencer.sv | 121 ++++++++++++
 tb/tb_frame_swap_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_swap_sequencer_pkg.sv
// Shared framebuffer geometry, pixel format and sequencer state encoding.
// The framebuffer side imports the same geometry constants.
package frame_swap_sequencer_pkg;

    localparam int PIX_W     = 12;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_AW     = 17;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILL    = 2'd1;
    localparam logic [1:0] ST_REQ     = 2'd2;
    localparam logic [1:0] ST_BACKOFF = 2'd3;

endpackage

// File: rtl/frame_swap_sequencer_swap_handshake_timer.sv
// Shared down-counter for the bank-flip request timeout and the retry backoff.
// The mode bit records which interval is running so each terminal count has its own flag.
module swap_handshake_timer #(
    parameter int unsigned SWAP_TIMEOUT = 1700000,
    parameter int unsigned BACKOFF_LEN  = 8
) (
    input  logic clk_sys,
    input  logic rst_n_sys,
    input  logic load_timeout,
    input  logic load_backoff,
    output logic timeout_hit,
    output logic backoff_done
);

    localparam int unsigned MAX_LEN = (SWAP_TIMEOUT > BACKOFF_LEN) ? SWAP_TIMEOUT : BACKOFF_LEN;
    localparam int          CW      = $clog2(MAX_LEN + 1);

    logic [CW-1:0] cnt;
    logic          in_backoff;
    logic          tc;

    always_ff @(posedge clk_sys) begin
        if (!rst_n_sys) begin
            cnt        <= '0;
            in_backoff <= 1'b0;
        end else if (load_timeout) begin
            cnt        <= CW'(SWAP_TIMEOUT - 1);
            in_backoff <= 1'b0;
        end else if (load_backoff) begin
            cnt        <= CW'(BACKOFF_LEN - 1);
            in_backoff <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tc           = (cnt == '0);
    assign timeout_hit  = tc && !in_backoff;
    assign backoff_done = tc && in_backoff;

endmodule

// File: rtl/frame_swap_sequencer.sv
// Fills one framebuffer bank from a pixel stream, then requests a bank flip and
// waits for the display side to confirm it, retrying with backoff on timeout.
//
// state   | meaning
// IDLE    | waiting for start_sys
// FILL    | accepting pixels, one write per accepted beat
// REQ     | swap_req_sys high, waiting for active_buf_sys to change
// BACKOFF | request dropped for BACKOFF_LEN cycles before retrying
module frame_swap_sequencer
    import frame_swap_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH        = FB_DEPTH,
    parameter int unsigned AW           = FB_AW,
    parameter int unsigned SWAP_TIMEOUT = 1700000,
    parameter int unsigned BACKOFF_LEN  = 8
) (
    input  logic             clk_sys,
    input  logic             rst_n_sys,
    input  logic             start_sys,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    output logic             s_ready,
    output logic             wr_en_sys,
    output logic [AW-1:0]    wr_addr_sys,
    output logic [PIX_W-1:0] wr_data_sys,
    output logic             swap_req_sys,
    input  logic             active_buf_sys,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic [7:0]       retry_count
);

    logic [1:0]    state;
    logic [AW-1:0] pix_cnt;
    logic          bank_ref;
    logic          accept;
    logic          last_beat;
    logic          flip;
    logic          load_timeout;
    logic          load_backoff;
    logic          timeout_hit;
    logic          backoff_done;

    assign s_ready      = (state == ST_FILL);
    assign busy         = (state != ST_IDLE);
    assign swap_req_sys = (state == ST_REQ);

    assign accept    = s_valid && s_ready;
    assign last_beat = accept && (pix_cnt == AW'(DEPTH - 1));
    assign flip      = (active_buf_sys != bank_ref);

    // A flip always beats a coincident terminal count, so loads are gated by !flip.
    assign load_timeout = last_beat || ((state == ST_BACKOFF) && !flip && backoff_done);
    assign load_backoff = (state == ST_REQ) && !flip && timeout_hit;

    swap_handshake_timer #(
        .SWAP_TIMEOUT (SWAP_TIMEOUT),
        .BACKOFF_LEN  (BACKOFF_LEN)
    ) u_timer (
        .clk_sys      (clk_sys),
        .rst_n_sys    (rst_n_sys),
        .load_timeout (load_timeout),
        .load_backoff (load_backoff),
        .timeout_hit  (timeout_hit),
        .backoff_done (backoff_done)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_n_sys) begin
            state       <= ST_IDLE;
            pix_cnt     <= '0;
            wr_en_sys   <= 1'b0;
            wr_addr_sys <= '0;
            wr_data_sys <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            retry_count <= '0;
            bank_ref    <= 1'b0;
        end else begin
            wr_en_sys  <= accept;
            frame_done <= 1'b0;
            if (accept) begin
                wr_addr_sys <= pix_cnt;
                wr_data_sys <= s_data;
                pix_cnt     <= pix_cnt + AW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start_sys) begin
                        pix_cnt <= '0;
                        state   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (last_beat) begin
                        state    <= ST_REQ;
                        bank_ref <= active_buf_sys;
                    end
                end
                ST_REQ, ST_BACKOFF: begin
                    if (flip) begin
                        state       <= ST_IDLE;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else if ((state == ST_REQ) && timeout_hit) begin
                        state <= ST_BACKOFF;
                        if (retry_count != 8'hFF) begin
                            retry_count <= retry_count + 8'd1;
                        end
                    end else if ((state == ST_BACKOFF) && backoff_done) begin
                        state    <= ST_REQ;
                        bank_ref <= active_buf_sys;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_swap_sequencer.sv
// Scoreboard bench: stimulus queues expected writes (with their due cycle), a negedge
// monitor pops and compares them; control outputs are checked directly by the stimulus.
module tb_frame_swap_sequencer;

    localparam int DEPTH = 64;
    localparam int AW    = 17;
    localparam int TO    = 100;
    localparam int BL    = 8;

    logic          clk_sys = 1'b0;
    logic          rst_n_sys = 1'b0;
    logic          start_sys = 1'b0;
    logic          s_valid = 1'b0;
    logic [11:0]   s_data = '0;
    logic          active_buf_sys = 1'b0;
    logic          s_ready;
    logic          wr_en_sys;
    logic [AW-1:0] wr_addr_sys;
    logic [11:0]   wr_data_sys;
    logic          swap_req_sys;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic [7:0]    retry_count;

    frame_swap_sequencer #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .SWAP_TIMEOUT (TO),
        .BACKOFF_LEN  (BL)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_n_sys      (rst_n_sys),
        .start_sys      (start_sys),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .wr_en_sys      (wr_en_sys),
        .wr_addr_sys    (wr_addr_sys),
        .wr_data_sys    (wr_data_sys),
        .swap_req_sys   (swap_req_sys),
        .active_buf_sys (active_buf_sys),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .retry_count    (retry_count)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write must match the head of the queue at exactly its due cycle.
    always @(negedge clk_sys) begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_write: addr %0d due cycle %0d, still absent at cycle %0d",
                     exp_q[0].addr, exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        if (wr_en_sys === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr_sys), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data_sys), 32'(mon_e.data));
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, expected no write",
                         wr_addr_sys, wr_data_sys, cyc);
            end
        end
    end

    // Drive one cycle starting right after a negedge; queue the write if this beat is accepted.
    task automatic beat(input logic v, input logic [11:0] d, input logic push, input logic [AW-1:0] a);
        s_valid = v;
        s_data  = d;
        if (v && push) exp_q.push_back('{cyc + 1, a, d});
        @(negedge clk_sys);
    endtask

    task automatic fill(input int first, input int n, input logic toggle, input logic [11:0] key);
        int a = first;
        for (int i = 0; a < first + n; i++) begin
            if (toggle && (i % 2 == 1)) begin
                beat(1'b0, 12'h000, 1'b0, '0);
            end else begin
                beat(1'b1, 12'(a) ^ key, 1'b1, AW'(a));
                a++;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic start_frame(input string tag);
        start_sys = 1'b1;
        @(negedge clk_sys);
        start_sys = 1'b0;
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en_sys), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr_sys), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data_sys), 32'd0);
        check({tag, "_swap_req"}, 32'(swap_req_sys), 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        check({tag, "_retry_count"}, 32'(retry_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_n_sys = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_zero("reset");
        rst_n_sys = 1'b1;
        @(negedge clk_sys);

        // Full frame, continuous valid, data = addr[11:0]; extra valid beats in REQ must not write
        start_frame("f1_start");
        fill(0, DEPTH, 1'b0, 12'h000);
        check("f1_swap_req_after_last", 32'(swap_req_sys), 32'd1);
        check("f1_s_ready_after_last", 32'(s_ready), 32'd0);
        repeat (3) beat(1'b1, 12'hFFF, 1'b0, '0);
        s_valid = 1'b0;
        repeat (46) @(negedge clk_sys);
        active_buf_sys = 1'b1;
        @(negedge clk_sys);
        check("f1_swap_req_fall", 32'(swap_req_sys), 32'd0);
        check("f1_frame_done", 32'(frame_done), 32'd1);
        check("f1_busy", 32'(busy), 32'd0);
        check("f1_frame_count", 32'(frame_count), 32'd1);
        check("f1_retry_count", 32'(retry_count), 32'd0);
        @(negedge clk_sys);
        check("f1_frame_done_pulse", 32'(frame_done), 32'd0);

        // Toggled valid for the first 10 pixels, then timeout/backoff cycling, then flip coinciding with timeout
        start_frame("f2_start");
        fill(0, 10, 1'b1, 12'h5A5);
        fill(10, DEPTH - 10, 1'b0, 12'h5A5);
        for (int k = 0; k < 424; k++) begin
            check("f2_swap_req_pattern", 32'(swap_req_sys), ((k % (TO + BL)) < TO) ? 32'd1 : 32'd0);
            check("f2_retry_count", 32'(retry_count),
                  32'(k / (TO + BL) + (((k % (TO + BL)) >= TO) ? 1 : 0)));
            if (k == 423) active_buf_sys = 1'b0;
            @(negedge clk_sys);
        end
        check("f2_tie_frame_done", 32'(frame_done), 32'd1);
        check("f2_tie_retry_count", 32'(retry_count), 32'd3);
        check("f2_tie_frame_count", 32'(frame_count), 32'd2);
        check("f2_tie_swap_req", 32'(swap_req_sys), 32'd0);
        check("f2_tie_busy", 32'(busy), 32'd0);

        // Reset mid-fill abandons the frame; IDLE ignores valid until a new start
        start_frame("f3_start");
        fill(0, 40, 1'b0, 12'h3C3);
        s_valid   = 1'b1;
        rst_n_sys = 1'b0;
        @(negedge clk_sys);
        check_zero("midfill_reset");
        rst_n_sys = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("post_reset_s_ready", 32'(s_ready), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        s_valid = 1'b0;

        // Refill from address 0; start during REQ is ignored
        start_frame("f4_start");
        fill(0, DEPTH, 1'b0, 12'hA5A);
        check("f4_swap_req", 32'(swap_req_sys), 32'd1);
        start_sys = 1'b1;
        @(negedge clk_sys);
        start_sys = 1'b0;
        check("f4_start_ignored_swap_req", 32'(swap_req_sys), 32'd1);
        check("f4_start_ignored_s_ready", 32'(s_ready), 32'd0);
        repeat (5) @(negedge clk_sys);
        check("f4_still_req", 32'(swap_req_sys), 32'd1);
        active_buf_sys = 1'b1;
        @(negedge clk_sys);
        check("f4_frame_done", 32'(frame_done), 32'd1);
        check("f4_frame_count", 32'(frame_count), 32'd1);
        check("f4_retry_count", 32'(retry_count), 32'd0);

        repeat (3) @(negedge clk_sys);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
